// File: rtl/ram_arbiter_pkg.sv
// Shared types and helpers for the RAM arbiter and its round-robin picker.
package ram_arbiter_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int DEFAULT_CLEAR_VALUE = 0;

  // Pointer width for N requesters; at least one bit even for N == 1.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first request at or after ptr, wrapping.
module rr_pick
  import ram_arbiter_pkg::*;
#(
  parameter int N = 2,
  localparam int PW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx,
  output logic          found
);

  // Upper pass covers ptr..N-1; the wrap pass then takes the lowest request.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (!found && req[j] && (PW'(j) >= ptr)) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = PW'(j);
      end
    end
    for (int j = 0; j < N; j++) begin
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = PW'(j);
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter with burst lock sharing one single-port RAM among N
// requesters; clears the whole RAM after reset before accepting requests.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int A = 8,
  parameter int D = 8,
  parameter int N = 2,
  parameter logic [D-1:0] CLEAR_VALUE = D'(DEFAULT_CLEAR_VALUE)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req_valid,
  input  logic [N-1:0]   req_we,
  input  logic [N-1:0]   req_lock,
  input  logic [N*A-1:0] req_addr,
  input  logic [N*D-1:0] req_wdata,
  output logic [N-1:0]   req_ready,
  output logic [N-1:0]   rsp_valid,
  output logic [D-1:0]   rsp_rdata,
  output logic           init_done,
  output logic [A-1:0]   ram_address,
  output logic [D-1:0]   ram_dbusi,
  input  logic [D-1:0]   ram_dbuso,
  output logic           ram_ce,
  output logic           ram_we
);

  localparam int PW = clog2(N);
  localparam logic [A:0] SWEEP_END = {1'b1, {A{1'b0}}};

  state_t        state;
  logic [A:0]    sweep_cnt;
  logic [PW-1:0] rr_ptr;
  logic          lock_valid;
  logic [PW-1:0] lock_id;
  logic          acc_valid;
  logic [PW-1:0] acc_id;

  logic [N-1:0]  pick_grant;
  logic [PW-1:0] pick_idx;
  logic          pick_found;
  logic [N-1:0]  grant;
  logic [PW-1:0] win_idx;
  logic [PW-1:0] next_ptr;
  logic          accept;

  rr_pick #(.N(N)) u_rr_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // A lock owner that is still requesting overrides the round-robin choice.
  always_comb begin
    win_idx = pick_idx;
    grant   = pick_grant;
    if (lock_valid && req_valid[lock_id]) begin
      win_idx          = lock_id;
      grant            = '0;
      grant[lock_id]   = 1'b1;
    end
  end

  assign accept    = (state == ST_RUN) && rst_n && pick_found;
  assign req_ready = accept ? grant : '0;
  assign next_ptr  = (win_idx == PW'(N - 1)) ? '0 : win_idx + PW'(1);

  // The ram_* registers double as the access stage; ram_dbuso is sampled
  // at the end of the access cycle, before the write commits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_INIT;
      sweep_cnt   <= '0;
      rr_ptr      <= '0;
      lock_valid  <= 1'b0;
      lock_id     <= '0;
      acc_valid   <= 1'b0;
      acc_id      <= '0;
      rsp_valid   <= '0;
      rsp_rdata   <= '0;
      init_done   <= 1'b0;
      ram_ce      <= 1'b0;
      ram_we      <= 1'b0;
      ram_address <= '0;
      ram_dbusi   <= '0;
    end else begin
      rsp_valid <= '0;
      if (acc_valid) begin
        rsp_valid[acc_id] <= 1'b1;
        rsp_rdata         <= ram_dbuso;
      end
      acc_valid <= 1'b0;
      case (state)
        ST_INIT: begin
          if (sweep_cnt == SWEEP_END) begin
            state     <= ST_RUN;
            init_done <= 1'b1;
            ram_ce    <= 1'b0;
            ram_we    <= 1'b0;
          end else begin
            ram_ce      <= 1'b1;
            ram_we      <= 1'b1;
            ram_address <= sweep_cnt[A-1:0];
            ram_dbusi   <= CLEAR_VALUE;
            sweep_cnt   <= sweep_cnt + (A+1)'(1);
          end
        end
        ST_RUN: begin
          if (accept) begin
            acc_valid   <= 1'b1;
            acc_id      <= win_idx;
            ram_ce      <= 1'b1;
            ram_we      <= req_we[win_idx];
            ram_address <= req_addr[win_idx*A +: A];
            ram_dbusi   <= req_wdata[win_idx*D +: D];
            rr_ptr      <= next_ptr;
            lock_valid  <= req_lock[win_idx];
            lock_id     <= win_idx;
          end else begin
            ram_ce     <= 1'b0;
            ram_we     <= 1'b0;
            lock_valid <= 1'b0;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural single-port RAM attached.
module tb_ram_arbiter;

  localparam int A = 5;
  localparam int D = 8;
  localparam int N = 2;
  localparam logic [D-1:0] CLEAR = 8'h5A;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_we;
  logic [N-1:0]   req_lock;
  logic [N*A-1:0] req_addr;
  logic [N*D-1:0] req_wdata;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   rsp_valid;
  logic [D-1:0]   rsp_rdata;
  logic           init_done;
  logic [A-1:0]   ram_address;
  logic [D-1:0]   ram_dbusi;
  logic [D-1:0]   ram_dbuso;
  logic           ram_ce;
  logic           ram_we;

  logic [D-1:0] mem [0:(1<<A)-1];

  int checks;
  int failures;

  ram_arbiter #(.A(A), .D(D), .N(N), .CLEAR_VALUE(CLEAR)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_we      (req_we),
    .req_lock    (req_lock),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .init_done   (init_done),
    .ram_address (ram_address),
    .ram_dbusi   (ram_dbusi),
    .ram_dbuso   (ram_dbuso),
    .ram_ce      (ram_ce),
    .ram_we      (ram_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM: asynchronous read, write on the clock edge.
  always @(posedge clk) if (ram_ce && ram_we) mem[ram_address] <= ram_dbusi;
  assign ram_dbuso = mem[ram_address];

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [N-1:0] valid, input logic [N-1:0] we,
                               input logic [N-1:0] lock,
                               input logic [A-1:0] a0, input logic [A-1:0] a1,
                               input logic [D-1:0] w0, input logic [D-1:0] w1);
    req_valid = valid;
    req_we    = we;
    req_lock  = lock;
    req_addr  = {a1, a0};
    req_wdata = {w1, w0};
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [N-1:0] exp_ready;
    logic [N-1:0] exp_rsp;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    applyStimulus('0, '0, '0, '0, '0, '0, '0);
    repeat (3) nextCycle();

    checkOutput("rst_ready", req_ready, 0);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_rsp_rdata", rsp_rdata, 0);
    checkOutput("rst_init_done", init_done, 0);
    checkOutput("rst_ram", {ram_ce, ram_we, ram_address, ram_dbusi}, 0);

    // Requester 0 waits with a read of address 7 through the whole sweep.
    rst_n = 1'b1;
    applyStimulus(2'b01, 2'b00, 2'b00, 5'd7, 5'd0, 8'h00, 8'h00);
    checkOutput("init_ready_start", req_ready, 0);
    for (int i = 0; i < (1 << A); i++) begin
      nextCycle();
      checkOutput("sweep_write", {ram_ce, ram_we, ram_address, ram_dbusi},
                  {2'b11, 5'(i), CLEAR});
      checkOutput("sweep_ready", req_ready, 0);
      checkOutput("sweep_done", init_done, 0);
    end

    nextCycle();
    checkOutput("init_done_rise", init_done, 1);
    checkOutput("first_run_idle_ce", ram_ce, 0);
    checkOutput("first_run_accept", req_ready, 2'b01);
    nextCycle();
    applyStimulus('0, '0, '0, '0, '0, '0, '0);
    checkOutput("access_rd7", {ram_ce, ram_we, ram_address}, {2'b10, 5'd7});
    checkOutput("idle_ready", req_ready, 0);
    nextCycle();
    checkOutput("rsp_valid_rd7", rsp_valid, 2'b01);
    checkOutput("rsp_rdata_rd7", rsp_rdata, 8'h5A);
    nextCycle();
    checkOutput("rsp_pulse_end", rsp_valid, 0);
    checkOutput("rsp_rdata_hold", rsp_rdata, 8'h5A);

    // Requester 1 writes 0x00 to 0x10; the response carries the cleared word.
    applyStimulus(2'b10, 2'b10, 2'b00, 5'd0, 5'h10, 8'h00, 8'h00);
    checkOutput("prep_ready", req_ready, 2'b10);
    nextCycle();
    applyStimulus('0, '0, '0, '0, '0, '0, '0);
    nextCycle();
    checkOutput("prep_rsp_valid", rsp_valid, 2'b10);
    checkOutput("prep_rsp_old", rsp_rdata, 8'h5A);
    nextCycle();
    checkOutput("prep_rsp_end", rsp_valid, 0);
    nextCycle();

    // Both requesters read continuously: grants alternate, responses 2 later.
    for (int k = 0; k < 6; k++) begin
      applyStimulus(2'b11, 2'b00, 2'b00, 5'd7, 5'h10, 8'h00, 8'h00);
      exp_ready = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_rsp   = (k < 2) ? 2'b00 : exp_ready;
      checkOutput("rr_grant", req_ready, exp_ready);
      checkOutput("rr_rsp_valid", rsp_valid, exp_rsp);
      if (k >= 2)
        checkOutput("rr_rsp_rdata", rsp_rdata, (k % 2 == 0) ? 8'h5A : 8'h00);
      nextCycle();
    end
    applyStimulus('0, '0, '0, '0, '0, '0, '0);
    checkOutput("rr_tail_rsp0", rsp_valid, 2'b01);
    checkOutput("rr_tail_data0", rsp_rdata, 8'h5A);
    nextCycle();
    checkOutput("rr_tail_rsp1", rsp_valid, 2'b10);
    checkOutput("rr_tail_data1", rsp_rdata, 8'h00);
    nextCycle();
    checkOutput("rr_tail_idle", rsp_valid, 0);

    // Write 0xC3 to 0x10 then read it back on the very next cycle.
    applyStimulus(2'b01, 2'b01, 2'b00, 5'h10, 5'd0, 8'hC3, 8'h00);
    checkOutput("fwd_wr_ready", req_ready, 2'b01);
    nextCycle();
    applyStimulus(2'b01, 2'b00, 2'b00, 5'h10, 5'd0, 8'hC3, 8'h00);
    checkOutput("fwd_rd_ready", req_ready, 2'b01);
    checkOutput("fwd_wr_access", {ram_ce, ram_we, ram_address, ram_dbusi},
                {2'b11, 5'h10, 8'hC3});
    nextCycle();
    applyStimulus('0, '0, '0, '0, '0, '0, '0);
    checkOutput("fwd_wr_rsp", rsp_valid, 2'b01);
    checkOutput("fwd_wr_old", rsp_rdata, 8'h00);
    nextCycle();
    checkOutput("fwd_rd_rsp", rsp_valid, 2'b01);
    checkOutput("fwd_rd_new", rsp_rdata, 8'hC3);
    nextCycle();
    checkOutput("fwd_idle", rsp_valid, 0);
    nextCycle();

    // Requester 1 bursts four reads, locking on the first three.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(2'b11, 2'b00, 2'b10, 5'd7, 5'h10, 8'h00, 8'h00);
      checkOutput("lock_grant", req_ready, 2'b10);
      nextCycle();
    end
    applyStimulus(2'b11, 2'b00, 2'b00, 5'd7, 5'h10, 8'h00, 8'h00);
    checkOutput("lock_last_grant", req_ready, 2'b10);
    nextCycle();
    applyStimulus(2'b01, 2'b00, 2'b00, 5'd7, 5'h10, 8'h00, 8'h00);
    checkOutput("lock_release_grant", req_ready, 2'b01);
    checkOutput("lock_rsp3", rsp_valid, 2'b10);
    checkOutput("lock_rsp3_data", rsp_rdata, 8'hC3);
    nextCycle();
    applyStimulus('0, '0, '0, '0, '0, '0, '0);
    checkOutput("lock_rsp4", rsp_valid, 2'b10);
    nextCycle();
    checkOutput("lock_rsp_r0", rsp_valid, 2'b01);
    checkOutput("lock_rsp_r0_data", rsp_rdata, 8'h5A);
    nextCycle();
    checkOutput("lock_idle", rsp_valid, 0);

    // Reset lands while a read sits in the access stage.
    applyStimulus(2'b01, 2'b00, 2'b00, 5'd7, 5'd0, 8'h00, 8'h00);
    checkOutput("mid_accept", req_ready, 2'b01);
    nextCycle();
    applyStimulus('0, '0, '0, '0, '0, '0, '0);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_access", {ram_ce, ram_address}, {1'b1, 5'd7});
    nextCycle();
    rst_n = 1'b1;
    checkOutput("mid_no_rsp", rsp_valid, 0);
    checkOutput("mid_init_done", init_done, 0);
    checkOutput("mid_ram_idle", {ram_ce, ram_we, ram_address}, 0);
    nextCycle();
    checkOutput("mid_sweep0", {ram_ce, ram_we, ram_address, ram_dbusi},
                {2'b11, 5'd0, CLEAR});
    checkOutput("mid_no_rsp_late", rsp_valid, 0);
    nextCycle();
    checkOutput("mid_sweep1", {ram_ce, ram_we, ram_address}, {2'b11, 5'd1});
    checkOutput("mid_done_low", init_done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
